// File: rtl/dmem_pkg.sv
// Shared state type, funct3 codes and lane/alignment helpers for dmem_responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] lane);
      logic [3:0] m;
      case (f3[1:0])
         2'b00:   m = 4'b0001 << lane;
         2'b01:   m = 4'b0011 << lane;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Unsigned loads have no store counterpart, so they are illegal with MemWrite.
   function automatic logic subword_err(input logic [2:0] f3, input logic we, input logic [1:0] lane);
      logic e;
      case (f3)
         F3_B:    e = 1'b0;
         F3_H:    e = lane[0];
         F3_W:    e = |lane;
         F3_BU:   e = we;
         F3_HU:   e = we | lane[0];
         default: e = 1'b1;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Sub-word lane steering: store byte enables and data replication, load shift and extension.
// Only built when DMEM_SUBWORD_EN is defined.
`ifdef DMEM_SUBWORD_EN
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata
);
   logic [15:0] shifted_s;

   // Lane decode for both directions.
   always_comb begin
      be        = lane_mask(funct3, lane);
      shifted_s = 16'(rword >> {lane, 3'b000});
      case (funct3[1:0])
         2'b00:   wdata_rep = {4{wdata[7:0]}};
         2'b01:   wdata_rep = {2{wdata[15:0]}};
         default: wdata_rep = wdata;
      endcase
      case (funct3)
         F3_B:    rdata = {{24{shifted_s[7]}}, shifted_s[7:0]};
         F3_H:    rdata = {{16{shifted_s[15]}}, shifted_s[15:0]};
         F3_BU:   rdata = {24'd0, shifted_s[7:0]};
         F3_HU:   rdata = {16'd0, shifted_s[15:0]};
         default: rdata = rword;
      endcase
   end
endmodule
`endif

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per handshake, WAIT_CYCLES wait states, one-cycle response.
// Define DMEM_SUBWORD_EN for byte/halfword accesses; otherwise every access is a full word.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   output logic        rsp_valid,
   output logic [31:0] ReadData,
   output logic        rsp_err
);
   localparam int         AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   state_t        state_r, state_s;
   logic [3:0]    cnt_r, cnt_s;
   logic          commit_s;
   logic [31:0]   adr_r, wdata_r;
   logic          we_r;
   logic [2:0]    f3_r;
   logic [31:0]   cur_adr_s, cur_wdata_s;
   logic          cur_we_s;
   logic [2:0]    cur_f3_s;
   logic          range_err_s, align_err_s, err_s;
   logic [AW-1:0] idx_s;
   logic [31:0]   rword_s, wrep_s, load_s;
   logic [3:0]    be_s;
   logic [31:0]   rdata_r;
   logic          err_r;
   logic [31:0]   mem_r [DEPTH_WORDS];

   // Next state; commit_s marks the edge that enters RESP.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      commit_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES > 0) begin
                  state_s = WAIT;
                  cnt_s   = 4'd1;
               end else begin
                  state_s  = RESP;
                  commit_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == WAIT_LAST) begin
               state_s  = RESP;
               commit_s = 1'b1;
            end else begin
               cnt_s = cnt_r + 4'd1;
            end
         end
         RESP: begin
            state_s = IDLE;
            cnt_s   = 4'd0;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // With zero wait states the commit happens on the accept edge, so IDLE uses the live request.
   always_comb begin
      if (state_r == IDLE) begin
         cur_adr_s   = DataAdr;
         cur_wdata_s = WriteData;
         cur_we_s    = MemWrite;
         cur_f3_s    = funct3;
      end else begin
         cur_adr_s   = adr_r;
         cur_wdata_s = wdata_r;
         cur_we_s    = we_r;
         cur_f3_s    = f3_r;
      end
   end

   assign range_err_s = |cur_adr_s[31:AW+2];
   assign idx_s       = cur_adr_s[AW+1:2];
   assign rword_s     = mem_r[idx_s];
   assign err_s       = range_err_s | align_err_s;

`ifdef DMEM_SUBWORD_EN
   assign align_err_s = subword_err(cur_f3_s, cur_we_s, cur_adr_s[1:0]);

   dmem_lane_align u_align (
      .funct3    (cur_f3_s),
      .lane      (cur_adr_s[1:0]),
      .wdata     (cur_wdata_s),
      .rword     (rword_s),
      .be        (be_s),
      .wdata_rep (wrep_s),
      .rdata     (load_s)
   );
`else
   logic unused_f3_s;
   assign unused_f3_s = ^cur_f3_s;
   assign align_err_s = |cur_adr_s[1:0];
   assign be_s        = 4'b1111;
   assign wrep_s      = cur_wdata_s;
   assign load_s      = rword_s;
`endif

   // State, request latch and response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
         adr_r   <= 32'd0;
         wdata_r <= 32'd0;
         we_r    <= 1'b0;
         f3_r    <= 3'd0;
         rdata_r <= 32'd0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         if (state_r == IDLE && req_valid) begin
            adr_r   <= DataAdr;
            wdata_r <= WriteData;
            we_r    <= MemWrite;
            f3_r    <= funct3;
         end
         if (commit_s) begin
            err_r   <= err_s;
            rdata_r <= (cur_we_s || err_s) ? 32'd0 : load_s;
         end
      end
   end

   // Array write on the edge entering RESP; contents are not cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset && commit_s && cur_we_s && !err_s) begin
         for (int b = 0; b < 4; b++) begin
            if (be_s[b]) mem_r[idx_s][8*b +: 8] <= wrep_s[8*b +: 8];
         end
      end
   end

   assign req_ready = (state_r == IDLE);
   assign rsp_valid = (state_r == RESP);
   assign ReadData  = rdata_r;
   assign rsp_err   = err_r;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: four instances with different wait-state counts,
// a byte-level memory/timing model checked every cycle, plus directed literal expectations.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int          N  = 4;
   localparam logic [15:0] WL = {4'd3, 4'd2, 4'd0, 4'd1};

   logic        clk = 1'b0;
   logic        reset     [N];
   logic        req_valid [N];
   logic        req_ready [N];
   logic [31:0] DataAdr   [N];
   logic [31:0] WriteData [N];
   logic        MemWrite  [N];
   logic [2:0]  funct3    [N];
   logic        rsp_valid [N];
   logic [31:0] ReadData  [N];
   logic        rsp_err   [N];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < N; g++) begin : g_dut
      dmem_responder #(
         .DEPTH_WORDS (64),
         .WAIT_CYCLES (int'(WL[4*g +: 4]))
      ) u_dut (
         .clk       (clk),
         .reset     (reset[g]),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .DataAdr   (DataAdr[g]),
         .WriteData (WriteData[g]),
         .MemWrite  (MemWrite[g]),
         .funct3    (funct3[g]),
         .rsp_valid (rsp_valid[g]),
         .ReadData  (ReadData[g]),
         .rsp_err   (rsp_err[g])
      );
   end

   function automatic int wc(input int i);
      return int'(WL[4*i +: 4]);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  mb [N][256];
   bit          pend    [N];
   bit          started [N];
   int          commit_at [N];
   int          rsp_at    [N] = '{default: -1};
   logic [31:0] m_adr [N];
   logic [31:0] m_wd  [N];
   logic        m_we  [N];
   logic [2:0]  m_f3  [N];
   logic [31:0] hold_rd [N];
   logic        exp_err [N];

   task automatic model_commit(input int i, output logic [31:0] rd, output logic er);
      int         size;
      bit         sgn, bad;
      logic [63:0] v;
`ifdef DMEM_SUBWORD_EN
      case (m_f3[i])
         3'b000:  begin size = 1; sgn = 1'b1; bad = 1'b0;    end
         3'b001:  begin size = 2; sgn = 1'b1; bad = 1'b0;    end
         3'b010:  begin size = 4; sgn = 1'b0; bad = 1'b0;    end
         3'b100:  begin size = 1; sgn = 1'b0; bad = m_we[i]; end
         3'b101:  begin size = 2; sgn = 1'b0; bad = m_we[i]; end
         default: begin size = 4; sgn = 1'b0; bad = 1'b1;    end
      endcase
`else
      size = 4; sgn = 1'b0; bad = 1'b0;
`endif
      if (m_adr[i] >= 32'd256) bad = 1'b1;
      else if ((int'(m_adr[i][7:0]) % size) != 0) bad = 1'b1;
      rd = 32'd0;
      er = bad;
      if (!bad) begin
         if (m_we[i]) begin
            for (int k = 0; k < size; k++) mb[i][int'(m_adr[i][7:0]) + k] = m_wd[i][8*k +: 8];
         end else begin
            v = 64'd0;
            for (int k = 0; k < size; k++) v[8*k +: 8] = mb[i][int'(m_adr[i][7:0]) + k];
            if (sgn && v[8*size-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*size));
            rd = v[31:0];
         end
      end
   endtask

   logic        c_rdy, c_vld, c_er;
   logic [31:0] c_rd;

   // Compare every instance against the model on each falling edge, then advance the model.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         c_vld = (rsp_at[i] == cyc);
         c_rdy = !(pend[i] || c_vld);
         if (started[i]) begin
            chk($sformatf("req_ready[%0d]", i), req_ready[i], c_rdy);
            chk($sformatf("rsp_valid[%0d]", i), rsp_valid[i], c_vld);
            chk($sformatf("ReadData[%0d]", i), ReadData[i], hold_rd[i]);
            if (c_vld) chk($sformatf("rsp_err[%0d]", i), rsp_err[i], exp_err[i]);
         end
         if (reset[i] === 1'b1) begin
            started[i] = 1'b1;
            pend[i]    = 1'b0;
            rsp_at[i]  = -1;
            hold_rd[i] = 32'd0;
         end else if (started[i]) begin
            if (req_valid[i] && c_rdy) begin
               pend[i]      = 1'b1;
               commit_at[i] = cyc + wc(i);
               m_adr[i]     = DataAdr[i];
               m_wd[i]      = WriteData[i];
               m_we[i]      = MemWrite[i];
               m_f3[i]      = funct3[i];
            end
            if (pend[i] && commit_at[i] == cyc) begin
               pend[i]   = 1'b0;
               rsp_at[i] = cyc + 1;
               model_commit(i, c_rd, c_er);
               hold_rd[i] = c_rd;
               exp_err[i] = c_er;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic xact(input int i, input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_er,
                       input int exp_lat);
      int          lat;
      bit          got;
      logic [31:0] rd;
      logic        er;
      @(posedge clk); #2;
      req_valid[i] = 1'b1; MemWrite[i] = we; DataAdr[i] = adr; WriteData[i] = wd; funct3[i] = f3;
      @(posedge clk); #2;
      req_valid[i] = 1'b0; MemWrite[i] = ~we; DataAdr[i] = 32'hFFFF_FFFC;
      WriteData[i] = ~wd; funct3[i] = 3'b111;
      got = 1'b0; lat = 0; rd = 32'd0; er = 1'b0;
      for (int n = 1; n <= 40 && !got; n++) begin
         if (n > 1) @(posedge clk);
         #1;
         if (n == 1) lat = 0;
         if (rsp_valid[i]) begin
            got = 1'b1; lat = n; rd = ReadData[i]; er = rsp_err[i];
         end
      end
      chk($sformatf("response seen [%0d] @%h", i, adr), 32'(got), 32'd1);
      chk($sformatf("latency [%0d] @%h", i, adr), lat, exp_lat);
      chk($sformatf("rdata [%0d] @%h", i, adr), rd, exp_rd);
      chk($sformatf("err [%0d] @%h", i, adr), 32'(er), 32'(exp_er));
   endtask

   initial begin
      int seen;
      for (int i = 0; i < N; i++) begin
         reset[i] = 1'b1; req_valid[i] = 1'b0; DataAdr[i] = 32'd0;
         WriteData[i] = 32'd0; MemWrite[i] = 1'b0; funct3[i] = F3_W;
      end
      repeat (3) @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) reset[i] = 1'b0;
      @(posedge clk); #1;
      chk("reset req_ready", 32'(req_ready[0]), 32'd1);
      chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("reset ReadData", ReadData[0], 32'd0);
      chk("reset rsp_err", 32'(rsp_err[0]), 32'd0);

      // store then load, one wait state
      xact(0, 1'b1, 32'h10, 32'hDEADBEEF, F3_W, 32'd0, 1'b0, 2);
      xact(0, 1'b0, 32'h10, 32'd0, F3_W, 32'hDEADBEEF, 1'b0, 2);

      // zero and three wait states
      xact(1, 1'b1, 32'h0, 32'h00C0FFEE, F3_W, 32'd0, 1'b0, 1);
      xact(1, 1'b0, 32'h0, 32'd0, F3_W, 32'h00C0FFEE, 1'b0, 1);
      xact(3, 1'b1, 32'h0, 32'h0BEEF000, F3_W, 32'd0, 1'b0, 4);
      xact(3, 1'b0, 32'h0, 32'd0, F3_W, 32'h0BEEF000, 1'b0, 4);

      // out of range: no write aliasing onto word 0
      xact(0, 1'b1, 32'h0, 32'h55AA55AA, F3_W, 32'd0, 1'b0, 2);
      xact(0, 1'b0, 32'h100, 32'd0, F3_W, 32'd0, 1'b1, 2);
      xact(0, 1'b1, 32'h100, 32'h0BADF00D, F3_W, 32'd0, 1'b1, 2);
      xact(0, 1'b0, 32'h0, 32'd0, F3_W, 32'h55AA55AA, 1'b0, 2);

      // reset during WAIT drops the store
      xact(2, 1'b1, 32'h20, 32'hCAFEF00D, F3_W, 32'd0, 1'b0, 3);
      @(posedge clk); #2;
      req_valid[2] = 1'b1; MemWrite[2] = 1'b1; DataAdr[2] = 32'h20;
      WriteData[2] = 32'h12345678; funct3[2] = F3_W;
      @(posedge clk); #2;
      req_valid[2] = 1'b0; reset[2] = 1'b1;
      @(posedge clk); #2;
      reset[2] = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (rsp_valid[2]) seen++;
      end
      chk("dropped request rsp_valid count", seen, 0);
      chk("ready after mid-op reset", 32'(req_ready[2]), 32'd1);
      xact(2, 1'b0, 32'h20, 32'd0, F3_W, 32'hCAFEF00D, 1'b0, 3);

`ifdef DMEM_SUBWORD_EN
      xact(0, 1'b1, 32'h8, 32'h11223344, F3_W, 32'd0, 1'b0, 2);
      xact(0, 1'b1, 32'hA, 32'h000000AA, F3_B, 32'd0, 1'b0, 2);
      xact(0, 1'b0, 32'h8, 32'd0, F3_W, 32'h11AA3344, 1'b0, 2);
      xact(0, 1'b0, 32'hA, 32'd0, F3_B, 32'hFFFFFFAA, 1'b0, 2);
      xact(0, 1'b0, 32'hA, 32'd0, F3_BU, 32'h000000AA, 1'b0, 2);
      xact(0, 1'b0, 32'h9, 32'd0, F3_H, 32'd0, 1'b1, 2);
      xact(0, 1'b0, 32'hA, 32'd0, F3_H, 32'h000011AA, 1'b0, 2);
      xact(0, 1'b1, 32'h8, 32'h0000BEEF, F3_H, 32'd0, 1'b0, 2);
      xact(0, 1'b0, 32'h8, 32'd0, F3_H, 32'hFFFFBEEF, 1'b0, 2);
      xact(0, 1'b0, 32'h8, 32'd0, F3_HU, 32'h0000BEEF, 1'b0, 2);
      xact(0, 1'b0, 32'h8, 32'd0, 3'b011, 32'd0, 1'b1, 2);
      xact(0, 1'b0, 32'h8, 32'd0, F3_W, 32'h11AABEEF, 1'b0, 2);
`else
      xact(0, 1'b1, 32'h8, 32'h11223344, F3_W, 32'd0, 1'b0, 2);
      xact(0, 1'b0, 32'h6, 32'd0, F3_W, 32'd0, 1'b1, 2);
      xact(0, 1'b0, 32'h8, 32'd0, F3_B, 32'h11223344, 1'b0, 2);
      xact(0, 1'b1, 32'h9, 32'hFFFFFFFF, F3_B, 32'd0, 1'b1, 2);
      xact(0, 1'b0, 32'h8, 32'd0, F3_W, 32'h11223344, 1'b0, 2);
`endif

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle core's load/store port.
- Accepts one request per handshake: address, write data, write enable and funct3.
- Stores into a word-organised RAM, or returns read data after a programmable number of wait states.
- Sits between the core datapath and the data memory array; it is the memory-side end of the DataAdr/WriteData/MemWrite/ReadData interface.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the array (power of two, 4..4096).
- WAIT_CYCLES, 1, wait states between accept and response (0..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- DataAdr  in  32  byte address.
- WriteData  in  32  store data, right-aligned.
- MemWrite  in  1  1 = store, 0 = load.
- funct3  in  3  access size/sign (RISC-V load/store funct3).
- rsp_valid  out  1  response strobe, one cycle.
- ReadData  out  32  load result, valid while rsp_valid.
- rsp_err  out  1  out-of-range or misaligned, valid while rsp_valid.

Behaviour:
- Reset state: FSM in IDLE, wait counter 0. Outputs: req_ready=1 (combinational, high only in IDLE), rsp_valid=0, ReadData=0, rsp_err=0.
- Reset does not clear array contents.
- States:
  - IDLE: accept when req_valid & req_ready, latching DataAdr, WriteData, MemWrite and funct3. Go to WAIT if WAIT_CYCLES>0, else RESP. No accept means stay in IDLE.
  - WAIT: counter counts 1..WAIT_CYCLES. On the last count go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accept edge. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Commit timing: the array write and the ReadData register load occur on the edge entering RESP.
- Stores:
  - ReadData=0 in RESP.
  - Only if no error: word index = addr[log2(DEPTH_WORDS)+1:2].
- Loads: ReadData holds the array word (sized per the feature below). ReadData is held after RESP until the next RESP or reset.
- Error cases:
  - Range check: addr >= DEPTH_WORDS*4 gives rsp_err=1, no write, ReadData=0.
  - Misaligned address gives rsp_err=1, no write, ReadData=0.
- Request inputs are ignored outside IDLE; the latched copy is authoritative.
- Reset mid-operation: the pending request is dropped with no write, unless the write edge has already passed. No rsp_valid is issued for the dropped request.
- Simultaneous reset and req_valid: reset wins, nothing is accepted.

Optional Feature:
- Macro DMEM_SUBWORD_EN.
- Defined:
  - funct3 decoded. Stores: 000 SB, 001 SH, 010 SW. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores write only the addressed byte lanes; other lanes are preserved.
  - Loads shift the selected lane to bit 0, then sign- or zero-extend.
  - Halfword needs addr[0]=0; word needs addr[1:0]=0. Otherwise rsp_err=1.
  - Undefined funct3 gives rsp_err=1.
- Undefined:
  - funct3 is ignored and every access is a full word.
  - addr[1:0]!=0 gives rsp_err=1.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, RESP};
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - function for the lane byte-enable mask.
- One sub-module, dmem_lane_align (combinational): store byte-enable and data replication, load shift and extension. It is present only under DMEM_SUBWORD_EN.

Test Plan:
1. Default parameters; store addr 0x10, data 0xDEADBEEF; then load 0x10 → store response has rsp_valid 2 cycles after accept, ReadData=0, rsp_err=0; load response has ReadData=0xDEADBEEF, rsp_err=0.
2. WAIT_CYCLES=0 and WAIT_CYCLES=3; load from 0x0 → rsp_valid 1 and 4 cycles after accept respectively; req_ready=0 from accept through RESP.
3. Load 0x100 with DEPTH_WORDS=64 → rsp_err=1, ReadData=0. Store 0x100 → rsp_err=1 and the array is unchanged (word 0 still reads its prior value).
4. Assert reset in the WAIT cycle of a store to 0x20 with data 0x12345678 (WAIT_CYCLES=2) → no rsp_valid; FSM returns to IDLE; a later load of 0x20 returns the old value.
5. With DMEM_SUBWORD_EN: store word 0x11223344 at 0x8, then SB 0xAA at 0xA → LW 0x8 returns 0x11AA3344. Then LB 0xA returns 0xFFFFFFAA, LBU 0xA returns 0x000000AA, LH 0x9 returns rsp_err=1.
6. Without the macro: load 0x6 → rsp_err=1; funct3=000 on a load of 0x8 returns the full word.
